// File: rtl/work_scheduler.sv
// work_scheduler
//   Drives the two chained sha256_transform hashers: generates the round
//   counter and feedback select, walks the nonce, and builds the first
//   hasher's state/data words. New work from serial_receive is double
//   buffered and swapped in only on a round boundary. Golden tickets
//   (hash2_top == 0 on a non-feedback result) are converted back to the
//   nonce that produced them, queued in a small FIFO and drained to
//   serial_transmit with a busy handshake.
//
//   Optional build macro: GOLDEN_DROP_CNT_EN adds a saturating drop_count
//   output counting golden nonces lost to a full FIFO.
//
// Ports
//   hash_clk       in   1    sole clock
//   reset          in   1    synchronous, active-high
//   work_valid     in   1    one-cycle pulse qualifying work_midstate/work_data
//   work_midstate  in   256  midstate of new work
//   work_data      in   96   data2[95:0] of new work
//   cnt            out  6    round counter to both hashers
//   feedback       out  1    feedback select to both hashers
//   hash_state     out  256  rx_state of first hasher
//   hash_data      out  512  rx_input of first hasher {padding, nonce, data}
//   hash2_top      in   32   hash2[255:224] from second hasher
//   tx_send        out  1    one-cycle send strobe
//   tx_word        out  32   golden nonce, stable until the next pop
//   tx_busy        in   1    serial_transmit busy
//   nonce          out  32   current nonce
//   exhausted      out  1    sticky, nonce space done for current work
//   drop_count     out  16   (GOLDEN_DROP_CNT_EN only) dropped golden pushes
module work_scheduler #(
    parameter int LOOP_LOG2       = 5,
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int FLUSH_CYCLES    = 160
) (
    input  logic         hash_clk,
    input  logic         reset,
    input  logic         work_valid,
    input  logic [255:0] work_midstate,
    input  logic [95:0]  work_data,
    output logic [5:0]   cnt,
    output logic         feedback,
    output logic [255:0] hash_state,
    output logic [511:0] hash_data,
    input  logic [31:0]  hash2_top,
    output logic         tx_send,
    output logic [31:0]  tx_word,
    input  logic         tx_busy,
    output logic [31:0]  nonce,
    output logic         exhausted
`ifdef GOLDEN_DROP_CNT_EN
    ,
    output logic [15:0]  drop_count
`endif
);

    localparam int          LOOP       = 1 << LOOP_LOG2;
    localparam logic [5:0]  CNT_MASK   = 6'(LOOP - 1);
    // Pipeline depth from nonce issue to golden flag, expressed in nonces.
    localparam int          OFFSET     = (LOOP == 1) ? 131 :
                                         (LOOP == 2) ? 66  : (1 << (7 - LOOP_LOG2)) + 1;
    localparam int          FIFO_DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int          PTR_W      = FIFO_DEPTH_LOG2 + 1;
    localparam int          FLUSH_W    = $clog2(FLUSH_CYCLES + 2);
    // SHA-256 padding of the 640-bit header: length word on top, 0x80 marker after the nonce.
    localparam logic [383:0] PAD       = {32'h0000_0280, 320'h0, 32'h8000_0000};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXH} state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;

    state_t               r_state;
    tx_state_t            r_tx_state;
    logic [5:0]           r_cnt;
    logic                 r_feedback;
    logic                 r_feedback_d1;
    logic [31:0]          r_nonce;
    logic                 r_exhausted;
    logic [255:0]         r_hash_state;
    logic [511:0]         r_hash_data;
    logic [FLUSH_W-1:0]   r_flush;
    logic                 r_golden_vld_p1;

    logic                 r_pend_vld;
    logic [255:0]         r_pend_mid;
    logic [95:0]          r_pend_data;
    logic [255:0]         r_act_mid;
    logic [95:0]          r_act_data;

    logic [31:0]          r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;

    logic                 r_tx_send;
    logic [31:0]          r_tx_word;
    logic                 r_busy_seen;
    logic [1:0]           r_tx_timer;

    logic [5:0]           w_cnt_next;
    logic                 w_fb_next;
    logic                 w_swap;
    logic [31:0]          w_nonce_next;
    logic                 w_exhaust;
    logic [255:0]         w_mid_next;
    logic [95:0]          w_data_next;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;
    logic                 w_pop;
    logic                 w_push;
    logic [31:0]          w_golden_nonce;
    logic [FIFO_DEPTH_LOG2-1:0] w_wr_idx;
    logic [FIFO_DEPTH_LOG2-1:0] w_rd_idx;

    // Round sequencing. The counter is frozen in IDLE, where it sits at 0,
    // so a pending work item is taken on the very next cycle.
    always_comb begin
        w_cnt_next   = r_cnt;
        w_fb_next    = 1'b0;
        w_swap       = 1'b0;
        w_nonce_next = r_nonce;
        w_exhaust    = 1'b0;
        if (r_state != S_IDLE) begin
            if (LOOP == 1) w_cnt_next = 6'd0;
            else           w_cnt_next = (r_cnt + 6'd1) & CNT_MASK;
        end
        w_fb_next = (LOOP != 1) && (w_cnt_next != 6'd0);
        w_swap    = r_pend_vld && (w_cnt_next == 6'd0);
        if (w_swap) begin
            w_nonce_next = 32'd0;
        end else if (r_state == S_RUN && !w_fb_next) begin
            if (r_nonce == 32'hFFFF_FFFF) w_exhaust    = 1'b1;
            else                          w_nonce_next = r_nonce + 32'd1;
        end
    end

    assign w_mid_next     = w_swap ? r_pend_mid  : r_act_mid;
    assign w_data_next    = w_swap ? r_pend_data : r_act_data;
    assign w_golden_nonce = r_nonce - 32'(OFFSET);

    // Golden-nonce FIFO; the extra pointer bit separates full from empty.
    assign w_wr_idx     = r_wr_ptr[FIFO_DEPTH_LOG2-1:0];
    assign w_rd_idx     = r_rd_ptr[FIFO_DEPTH_LOG2-1:0];
    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) && (w_wr_idx == w_rd_idx);
    assign w_pop        = (r_tx_state == TX_IDLE) && !w_fifo_empty && !tx_busy;
    // When full, a simultaneous pop frees the head slot, which the push then reuses.
    assign w_push       = r_golden_vld_p1 && (!w_fifo_full || w_pop);

    // Main FSM, counter, nonce, hasher words and golden detection.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= 6'd0;
            r_feedback      <= 1'b0;
            r_feedback_d1   <= 1'b0;
            r_nonce         <= 32'd0;
            r_exhausted     <= 1'b0;
            r_hash_state    <= 256'd0;
            r_hash_data     <= 512'd0;
            r_flush         <= '0;
            r_golden_vld_p1 <= 1'b0;
            r_pend_vld      <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_next;
            r_feedback    <= w_fb_next;
            r_nonce       <= w_nonce_next;
            r_feedback_d1 <= r_feedback;
            // Results taken while the pipeline still holds old work are not trusted.
            r_golden_vld_p1 <= (hash2_top == 32'd0) && !r_feedback_d1 &&
                               (r_state != S_IDLE) && (r_flush == '0);
            // Arriving work always lands in pending, even on the swap cycle.
            r_pend_vld <= work_valid || (r_pend_vld && !w_swap);
            if (w_swap)              r_flush <= FLUSH_W'(FLUSH_CYCLES);
            else if (r_flush != '0)  r_flush <= r_flush - 1'b1;
            if (r_state != S_IDLE || w_swap) begin
                r_hash_state <= w_mid_next;
                r_hash_data  <= {PAD, w_nonce_next, w_data_next};
            end
            if (w_swap) begin
                r_state     <= S_RUN;
                r_exhausted <= 1'b0;
            end else if (w_exhaust) begin
                r_state     <= S_EXH;
                r_exhausted <= 1'b1;
            end
        end
    end

    // Work buffers and FIFO storage carry data only.
    always_ff @(posedge hash_clk) begin
        if (work_valid) begin
            r_pend_mid  <= work_midstate;
            r_pend_data <= work_data;
        end
        if (w_swap) begin
            r_act_mid  <= r_pend_mid;
            r_act_data <= r_pend_data;
        end
        if (w_push) r_fifo[w_wr_idx] <= w_golden_nonce;
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Transmit handshake: strobe, then wait for busy to rise and fall.
    // If busy never rises within four cycles of the strobe, give up waiting.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_tx_state  <= TX_IDLE;
            r_tx_send   <= 1'b0;
            r_tx_word   <= 32'd0;
            r_busy_seen <= 1'b0;
            r_tx_timer  <= 2'd0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_pop) begin
                        r_tx_word  <= r_fifo[w_rd_idx];
                        r_tx_send  <= 1'b1;
                        r_tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    r_tx_send   <= 1'b0;
                    r_busy_seen <= 1'b0;
                    r_tx_timer  <= 2'd0;
                    r_tx_state  <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (!r_busy_seen) begin
                        if (tx_busy)                 r_busy_seen <= 1'b1;
                        else if (r_tx_timer == 2'd3) r_tx_state  <= TX_IDLE;
                        else                         r_tx_timer  <= r_tx_timer + 2'd1;
                    end else if (!tx_busy) begin
                        r_tx_state <= TX_IDLE;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

`ifdef GOLDEN_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop_count;

    assign w_drop = r_golden_vld_p1 && w_fifo_full && !w_pop;

    always_ff @(posedge hash_clk) begin
        if (reset)                                  r_drop_count <= 16'd0;
        else if (w_drop && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end

    assign drop_count = r_drop_count;
`endif

    assign cnt        = r_cnt;
    assign feedback   = r_feedback;
    assign hash_state = r_hash_state;
    assign hash_data  = r_hash_data;
    assign nonce      = r_nonce;
    assign exhausted  = r_exhausted;
    assign tx_send    = r_tx_send;
    assign tx_word    = r_tx_word;

endmodule
